// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline hazard / stall controller for a 5-stage in-order core.
//   Detects load-use hazards between EX and ID, squashes IF/ID on taken
//   branches, and freezes the back half of the pipe while data memory is busy.
//   A wait counter flags (sticky) a memory wait that lasts MEM_TIMEOUT cycles.
//
//   Parameters:
//     MEM_TIMEOUT  consecutive MEM_WAIT cycles before timeout (1..255)
//   Optional build macro:
//     HAZARD_STATS_EN  adds StallCnt_o, a saturating count of cycles with
//                      PCWrite_o=0 while out of reset.
//   Ports:
//     clk_i, rst_i (async, active-low)
//     IDRS1_i, IDRS2_i, IDUsesRS2_i  source operands of the ID instruction
//     EXRD_i, EXMemRead_i            destination / load flag of the EX instr.
//     Branch_i                       taken branch resolved in ID
//     MEMBusy_i                      data memory not ready
//     PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Hold_o  pipeline controls
//     MemTimeout_o                   sticky memory-wait overrun flag
//     State_o                        current FSM state (RUN/LU_STALL/MEM_WAIT)
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  IDRS1_i,
  input  logic [4:0]  IDRS2_i,
  input  logic        IDUsesRS2_i,
  input  logic [4:0]  EXRD_i,
  input  logic        EXMemRead_i,
  input  logic        Branch_i,
  input  logic        MEMBusy_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        NoOp_o,
  output logic        Flush_o,
  output logic        Hold_o,
  output logic        MemTimeout_o,
  output logic [1:0]  State_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] StallCnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  localparam logic [7:0] TMO8 = 8'(MEM_TIMEOUT);
  localparam logic [8:0] TMO9 = 9'(MEM_TIMEOUT);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt_q;
  logic       timeout_q;
  logic       lu;
  logic [8:0] wait_now;
  logic       timeout_now;

  assign lu = EXMemRead_i && (EXRD_i != '0) &&
              ((EXRD_i == IDRS1_i) || (IDUsesRS2_i && (EXRD_i == IDRS2_i)));

  // wait_cnt_q holds completed MEM_WAIT cycles; +1 includes the current one,
  // so the flag is visible during the MEM_TIMEOUT-th busy wait cycle itself.
  assign wait_now    = {1'b0, wait_cnt_q} + 9'd1;
  assign timeout_now = (state_q == MEM_WAIT) && MEMBusy_i && (wait_now >= TMO9);

  assign MemTimeout_o = timeout_q | timeout_now;
  assign State_o      = state_q;

  always_comb begin
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    NoOp_o      = 1'b0;
    Flush_o     = 1'b0;
    Hold_o      = 1'b0;
    state_d     = RUN;
    if (!rst_i) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOp_o      = 1'b1;
    end else if (MEMBusy_i) begin
      Hold_o      = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      state_d     = MEM_WAIT;
    end else begin
      case (state_q)
        // The MEM_WAIT exit cycle uses RUN output rules but always returns
        // to RUN, even when it raises a load-use stall.
        RUN, MEM_WAIT: begin
          if (lu) begin
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            NoOp_o      = 1'b1;
            state_d     = (state_q == RUN) ? LU_STALL : RUN;
          end else if (Branch_i) begin
            Flush_o = 1'b1;
          end
        end
        default: begin
          // LU_STALL (and the unused encoding): detection suppressed.
          if (Branch_i) Flush_o = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (MEMBusy_i) begin
        if (state_q != MEM_WAIT) wait_cnt_q <= '0;
        else if (wait_cnt_q < TMO8) wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (timeout_now) timeout_q <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (!PCWrite_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign StallCnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of consecutive MEM_WAIT cycles before a timeout is flagged; legal range is 1..255.
REQ-002 The block SHALL use one clock, clk_i, with reset asynchronous and active-low, named rst_i.
REQ-003 Ports, listed as name, direction, width, meaning:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- IDRS1_i  in  5  rs1 of the instruction in ID.
- IDRS2_i  in  5  rs2 of the instruction in ID.
- IDUsesRS2_i  in  1  the ID instruction reads rs2.
- EXRD_i  in  5  rd of the instruction in EX.
- EXMemRead_i  in  1  the EX instruction is a load.
- Branch_i  in  1  a taken branch is resolved in ID this cycle.
- MEMBusy_i  in  1  data memory is not ready; the MEM stage cannot complete.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register write enable.
- NoOp_o  out  1  zero the control bits entering ID/EX (bubble).
- Flush_o  out  1  clear IF/ID (branch squash).
- Hold_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- MemTimeout_o  out  1  sticky error flag for a memory wait overrun.
- State_o  out  2  current FSM state.

Function
REQ-004 The FSM SHALL have three states: RUN=2'b00, LU_STALL=2'b01, MEM_WAIT=2'b10. The encoding 2'b11 SHALL return to RUN on the next clock edge.
REQ-005 The load-use hazard condition (LU) SHALL be true when all of the following hold: EXMemRead_i=1, EXRD_i!=0, and either EXRD_i==IDRS1_i or (IDUsesRS2_i=1 and EXRD_i==IDRS2_i).
REQ-006 In every state, MEMBusy_i=1 SHALL have the highest priority and SHALL produce:
- Hold_o=1, PCWrite_o=0, IFIDWrite_o=0, NoOp_o=0, Flush_o=0.
- A transition to, or stay in, MEM_WAIT.
REQ-007 In RUN with MEMBusy_i=0 and LU=1, the outputs SHALL be PCWrite_o=0, IFIDWrite_o=0, NoOp_o=1, Flush_o=0, and the next state SHALL be LU_STALL. This stall is combinational, in the same cycle.
REQ-008 If Branch_i and LU are both true in RUN, the stall SHALL win and Flush_o SHALL be 0, because the branch re-resolves after the stall.
REQ-009 In RUN with MEMBusy_i=0, LU=0 and Branch_i=1, the outputs SHALL be Flush_o=1, PCWrite_o=1, IFIDWrite_o=1, and the state SHALL stay RUN.
REQ-010 In RUN with no event, the outputs SHALL be PCWrite_o=1, IFIDWrite_o=1, NoOp_o=0, Flush_o=0, Hold_o=0.
REQ-011 LU_STALL SHALL last exactly one cycle:
- LU detection is suppressed; outputs are as in RUN, except that Branch_i still produces Flush_o.
- The next state is RUN, unless MEMBusy_i=1.
REQ-012 A wait counter (8 bits) SHALL behave as follows:
- It clears on entry to MEM_WAIT and increments every cycle spent in MEM_WAIT.
- It saturates at MEM_TIMEOUT.
- When the count equals MEM_TIMEOUT while MEMBusy_i is still 1, MemTimeout_o SHALL be set and SHALL stay 1 until reset.
REQ-013 In MEM_WAIT with MEMBusy_i=0, the next state SHALL be RUN; that exit cycle SHALL evaluate LU and Branch_i with RUN rules.
REQ-014 State_o SHALL equal the registered state with zero latency.

Reset
REQ-015 While rst_i=0, the state SHALL be RUN and the wait counter SHALL be 0.
REQ-016 While rst_i=0, the outputs SHALL be PCWrite_o=0, IFIDWrite_o=0, NoOp_o=1, Flush_o=0, Hold_o=0, MemTimeout_o=0, State_o=2'b00.
REQ-017 Reset asserted mid-stall or mid-wait SHALL abort immediately; the first cycle after release SHALL be RUN.

Configuration
REQ-018 Macro HAZARD_STATS_EN, when defined, SHALL add output StallCnt_o, 16 bits:
- It counts cycles with PCWrite_o=0 and rst_i=1.
- It saturates at 16'hFFFF and resets to 0.
REQ-019 When HAZARD_STATS_EN is undefined, the StallCnt_o port and its counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-020 Load-use on rs1: EXMemRead_i=1, EXRD_i=5, IDRS1_i=5 -> one cycle of PCWrite_o=0 and NoOp_o=1, State_o=01, then RUN with PCWrite_o=1.
REQ-021 Suppression cases:
- EXRD_i=0 with IDRS1_i=0 and EXMemRead_i=1 -> no stall.
- IDUsesRS2_i=0 with EXRD_i==IDRS2_i=7 -> no stall.
REQ-022 Branch_i=1 together with an LU match -> Flush_o=0 and NoOp_o=1; branch only in RUN -> Flush_o=1.
REQ-023 MEM_TIMEOUT=3, MEMBusy_i held high for 5 cycles:
- Hold_o=1 throughout.
- MemTimeout_o rises at the 3rd MEM_WAIT cycle and stays 1 after MEMBusy_i drops.
REQ-024 rst_i pulled low during MEM_WAIT -> State_o=00 and Hold_o=0 immediately; with HAZARD_STATS_EN, StallCnt_o=0 after reset and counts 1 per stalled cycle.
